// File: rtl/stream_frame_ctrl.sv
// Frame sequencer for a memory-backed AXI-Stream sample source.
// Gates the source into fixed-length frames with per-frame tlast, inserts
// idle gaps between frames and re-arms the source after end of buffer.
module stream_frame_ctrl #(
    parameter int unsigned DATA_W     = 32,
    parameter int unsigned FRAME_LEN  = 1024,
    parameter int unsigned CNT_W      = 8,
    parameter int unsigned GAP_CYCLES = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cmd_go,
    input  logic              cmd_abort,
    input  logic [CNT_W-1:0]  cfg_num_frames,
    output logic              src_start,
    input  logic              s_tvalid,
    input  logic [DATA_W-1:0] s_tdata,
    input  logic              s_tlast,
    output logic              s_tready,
    output logic              m_tvalid,
    output logic [DATA_W-1:0] m_tdata,
    output logic              m_tlast,
    input  logic              m_tready,
    output logic              busy,
    output logic              done,
    output logic              aborted,
    output logic [CNT_W-1:0]  frame_cnt,
    output logic              err_src_last
);

    localparam int unsigned BEAT_W = $clog2(FRAME_LEN);
    localparam int unsigned GAP_W  = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
    localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(FRAME_LEN - 1);
    localparam logic [GAP_W-1:0]  GAP_LOAD  = GAP_W'(GAP_CYCLES - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_STREAM,
        S_GAP,
        S_DONE
    } state_t;

    state_t              state_q, state_d;
    logic [BEAT_W-1:0]   beat_cnt_q, beat_cnt_d;
    logic [GAP_W-1:0]    gap_cnt_q, gap_cnt_d;
    logic                rearm_q, rearm_d;
    logic [CNT_W-1:0]    target_q, target_d;
    logic [CNT_W-1:0]    frame_cnt_d;
    logic                aborted_d, err_d, src_start_d, done_d;
    logic                gate, hs, last_beat;
    logic [CNT_W-1:0]    frame_inc;

    // Pass-through gating: the stream only flows in STREAM and never in an abort cycle
    always_comb begin
        gate      = (state_q == S_STREAM) && !cmd_abort;
        m_tdata   = s_tdata;
        m_tvalid  = s_tvalid && gate;
        s_tready  = m_tready && gate;
        last_beat = (beat_cnt_q == LAST_BEAT);
        m_tlast   = gate && last_beat;
        hs        = s_tvalid && s_tready;
        frame_inc = frame_cnt + CNT_W'(1);
        busy      = (state_q != S_IDLE);
    end

    // Next-state and counter/status update logic
    always_comb begin
        state_d     = state_q;
        beat_cnt_d  = beat_cnt_q;
        gap_cnt_d   = gap_cnt_q;
        rearm_d     = rearm_q;
        target_d    = target_q;
        frame_cnt_d = frame_cnt;
        aborted_d   = aborted;
        err_d       = err_src_last;
        src_start_d = 1'b0;
        done_d      = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (cmd_go) begin
                    if (cfg_num_frames == '0) begin
                        done_d = 1'b1;
                    end else begin
                        target_d    = cfg_num_frames;
                        frame_cnt_d = '0;
                        aborted_d   = 1'b0;
                        err_d       = 1'b0;
                        state_d     = S_START;
                    end
                end
            end
            S_START: begin
                if (cmd_abort) begin
                    aborted_d  = 1'b1;
                    beat_cnt_d = '0;
                    state_d    = S_DONE;
                end else begin
                    rearm_d = 1'b0;
                    state_d = S_STREAM;
                end
            end
            S_STREAM: begin
                if (cmd_abort) begin
                    aborted_d  = 1'b1;
                    beat_cnt_d = '0;
                    state_d    = S_DONE;
                end else if (hs) begin
                    beat_cnt_d = beat_cnt_q + BEAT_W'(1);
                    if (s_tlast) begin
                        rearm_d = 1'b1;
                        if (!last_beat) begin
                            err_d = 1'b1;
                        end
                    end
                    if (last_beat) begin
                        frame_cnt_d = frame_inc;
                        if (frame_inc == target_q) begin
                            state_d = S_DONE;
                        end else if (GAP_CYCLES > 0) begin
                            gap_cnt_d = GAP_LOAD;
                            state_d   = S_GAP;
                        end else if (rearm_q || s_tlast) begin
                            state_d = S_START;
                        end
                    end
                end
            end
            S_GAP: begin
                if (cmd_abort) begin
                    aborted_d  = 1'b1;
                    beat_cnt_d = '0;
                    state_d    = S_DONE;
                end else if (gap_cnt_q == '0) begin
                    state_d = rearm_q ? S_START : S_STREAM;
                end else begin
                    gap_cnt_d = gap_cnt_q - GAP_W'(1);
                end
            end
            S_DONE: begin
                beat_cnt_d = '0;
                state_d    = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        if (state_d == S_START) begin
            src_start_d = 1'b1;
        end
        if (state_d == S_DONE) begin
            done_d = 1'b1;
        end
    end

    // State, counters and registered status outputs
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= S_IDLE;
            beat_cnt_q   <= '0;
            gap_cnt_q    <= '0;
            rearm_q      <= 1'b0;
            target_q     <= '0;
            frame_cnt    <= '0;
            aborted      <= 1'b0;
            err_src_last <= 1'b0;
            src_start    <= 1'b0;
            done         <= 1'b0;
        end else begin
            state_q      <= state_d;
            beat_cnt_q   <= beat_cnt_d;
            gap_cnt_q    <= gap_cnt_d;
            rearm_q      <= rearm_d;
            target_q     <= target_d;
            frame_cnt    <= frame_cnt_d;
            aborted      <= aborted_d;
            err_src_last <= err_d;
            src_start    <= src_start_d;
            done         <= done_d;
        end
    end

endmodule

// File: tb/tb_stream_frame_ctrl.sv
// Scoreboard bench for stream_frame_ctrl: random source/consumer stalls,
// expected beats queued at run start, monitor compares every transfer.
module tb_stream_frame_ctrl;

    localparam int DW  = 32;
    localparam int FL  = 8;
    localparam int CW  = 8;
    localparam int GAP = 2;

    logic          clk = 1'b0;
    logic          reset;
    logic          cmd_go, cmd_abort;
    logic [CW-1:0] cfg_num_frames;
    logic          src_start;
    logic          s_tvalid, s_tlast, s_tready;
    logic [DW-1:0] s_tdata, m_tdata;
    logic          m_tvalid, m_tlast, m_tready;
    logic          busy, done, aborted, err_src_last;
    logic [CW-1:0] frame_cnt;

    always #5 clk = ~clk;

    stream_frame_ctrl #(
        .DATA_W(DW), .FRAME_LEN(FL), .CNT_W(CW), .GAP_CYCLES(GAP)
    ) dut (
        .clk(clk), .reset(reset), .cmd_go(cmd_go), .cmd_abort(cmd_abort),
        .cfg_num_frames(cfg_num_frames), .src_start(src_start),
        .s_tvalid(s_tvalid), .s_tdata(s_tdata), .s_tlast(s_tlast),
        .s_tready(s_tready), .m_tvalid(m_tvalid), .m_tdata(m_tdata),
        .m_tlast(m_tlast), .m_tready(m_tready), .busy(busy), .done(done),
        .aborted(aborted), .frame_cnt(frame_cnt), .err_src_last(err_src_last)
    );

    typedef struct packed {
        logic [DW-1:0] data;
        logic          last;
    } beat_t;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    beat_t         exp_q[$];
    logic [DW-1:0] src_data [0:4095];
    int            src_ptr = 0, src_pos = 0, buf_len = 1000;
    int            vmode = 0, rmode = 0;
    bit            hs_s = 1'b0, start_s = 1'b0;
    int            start_cnt = 0, done_cnt = 0, run_hs = 0, done_cyc = 0, busy_cnt = 0;
    int            hs_cyc[$];
    int            start_cyc[$];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Expected source-restart count and error flag for a run, from the frame rules
    function automatic void model(input int n, input int bl, output int starts, output bit err);
        int pos;
        bit rearm;
        starts = 1; err = 1'b0; pos = 0; rearm = 1'b0;
        for (int f = 0; f < n; f++) begin
            for (int b = 0; b < FL; b++) begin
                if (pos == bl - 1) begin
                    rearm = 1'b1;
                    if (b != FL - 1) err = 1'b1;
                end
                pos++;
            end
            if (f < n - 1 && rearm) begin
                starts++;
                pos   = 0;
                rearm = 1'b0;
            end
        end
    endfunction

    // Source and consumer driver: memory-backed source restarted by src_start
    initial begin
        s_tvalid = 1'b0; s_tdata = '0; s_tlast = 1'b0; m_tready = 1'b0;
        forever begin
            @(posedge clk);
            if (start_s) src_pos = 0;
            if (hs_s) begin
                src_ptr++;
                src_pos++;
            end
            #1;
            s_tvalid = (vmode == 0) ? 1'b1 : ($urandom_range(0, 9) < 7);
            case (rmode)
                0:       m_tready = 1'b1;
                1:       m_tready = (cyc % 2 == 0);
                default: m_tready = ($urandom_range(0, 9) < 6);
            endcase
            s_tdata = src_data[src_ptr % 4096];
            s_tlast = (src_pos == buf_len - 1);
        end
    end

    // Monitor: pops expected beats on every output transfer
    initial begin
        beat_t e;
        forever begin
            @(negedge clk);
            hs_s    = s_tvalid && s_tready;
            start_s = src_start;
            if (src_start) begin
                start_cnt++;
                start_cyc.push_back(cyc);
            end
            if (done) begin
                done_cnt++;
                done_cyc = cyc;
            end
            if (busy) busy_cnt++;
            chk("hs_match", 64'(m_tvalid && m_tready), 64'(s_tvalid && s_tready));
            if (!busy) chk("idle_gate", 64'({m_tvalid, s_tready}), 64'd0);
            if (m_tvalid && m_tready) begin
                run_hs++;
                hs_cyc.push_back(cyc);
                if (exp_q.size() == 0) begin
                    chk("unexpected_beat", 64'(m_tdata), 64'hDEAD_0000_0000_0000);
                end else begin
                    e = exp_q.pop_front();
                    chk("beat_data", 64'(m_tdata), 64'(e.data));
                    chk("beat_last", 64'(m_tlast), 64'(e.last));
                end
            end
        end
    end

    task automatic go(input int n);
        @(posedge clk);
        #2 cmd_go = 1'b1; cfg_num_frames = CW'(n);
        @(posedge clk);
        #2 cmd_go = 1'b0;
    endtask

    task automatic wait_done(input int d0, input string nm);
        int n = 0;
        while (done_cnt == d0 && n < 3000) begin
            @(posedge clk);
            n++;
        end
        if (done_cnt == d0) begin
            total++;
            bad++;
            $display("FAIL %s timeout actual=no_done required=done", nm);
        end
    endtask

    task automatic push_exp(input int nbeats);
        beat_t e;
        int base = src_ptr;
        for (int k = 0; k < nbeats; k++) begin
            e.data = src_data[(base + k) % 4096];
            e.last = ((k % FL) == FL - 1);
            exp_q.push_back(e);
        end
    endtask

    task automatic run(input int n, input int bl, input int vm, input int rm, input bit timing);
        int starts, d0, s0, badd;
        bit err;
        model(n, bl, starts, err);
        vmode = vm; rmode = rm; buf_len = bl;
        @(posedge clk);
        push_exp(n * FL);
        hs_cyc.delete(); start_cyc.delete();
        run_hs = 0; d0 = done_cnt; s0 = start_cnt;
        go(n);
        wait_done(d0, "run_done");
        @(negedge clk);
        chk("frame_cnt", 64'(frame_cnt), 64'(n));
        chk("err_src_last", 64'(err_src_last), 64'(err));
        chk("aborted_clear", 64'(aborted), 64'd0);
        chk("busy_after", 64'(busy), 64'd0);
        chk("src_starts", 64'(start_cnt - s0), 64'(starts));
        chk("done_pulses", 64'(done_cnt - d0), 64'd1);
        chk("beats_left", 64'(exp_q.size()), 64'd0);
        if (timing && hs_cyc.size() == n * FL && start_cyc.size() > 0) begin
            chk("first_beat_lat", 64'(hs_cyc[0]), 64'(start_cyc[0] + 1));
            badd = 0;
            for (int k = 1; k < n * FL; k++) begin
                if (hs_cyc[k] - hs_cyc[k-1] != (((k % FL) == 0) ? GAP + 1 : 1)) badd++;
            end
            chk("beat_spacing", 64'(badd), 64'd0);
            chk("done_lat", 64'(done_cyc), 64'(hs_cyc[n*FL-1] + 1));
        end
        exp_q.delete();
    endtask

    initial begin
        int d0, s0, n, ab_cyc;
        int bls[7];
        bls = '{3, 4, 8, 12, 16, 40, 1000};
        for (int i = 0; i < 4096; i++) src_data[i] = $urandom;
        reset = 1'b1; cmd_go = 1'b0; cmd_abort = 1'b0; cfg_num_frames = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_outputs", 64'({busy, done, aborted, err_src_last, src_start, m_tvalid, s_tready, m_tlast}), 64'd0);
        chk("rst_frame_cnt", 64'(frame_cnt), 64'd0);
        @(posedge clk);
        #2 reset = 1'b0;

        // Full-rate run with exact timing, then consumer toggling
        run(3, 1000, 0, 0, 1);
        run(3, 1000, 0, 1, 0);

        // Zero-length run
        d0 = done_cnt; s0 = start_cnt; busy_cnt = 0;
        go(0);
        repeat (4) @(posedge clk);
        chk("zero_done", 64'(done_cnt - d0), 64'd1);
        chk("zero_busy", 64'(busy_cnt), 64'd0);
        chk("zero_start", 64'(start_cnt - s0), 64'd0);

        // Abort during beat 5 of the second frame
        vmode = 0; rmode = 0; buf_len = 1000;
        @(posedge clk);
        push_exp(FL + 5);
        run_hs = 0; d0 = done_cnt;
        go(3);
        n = 0;
        while (run_hs < FL + 5 && n < 3000) begin
            @(posedge clk);
            n++;
        end
        #2 cmd_abort = 1'b1; ab_cyc = cyc;
        @(negedge clk);
        chk("abort_no_hs", 64'({m_tvalid, s_tready}), 64'd0);
        @(posedge clk);
        #2 cmd_abort = 1'b0;
        wait_done(d0, "abort_done");
        @(negedge clk);
        chk("abort_done_lat", 64'(done_cyc), 64'(ab_cyc + 1));
        chk("abort_flag", 64'(aborted), 64'd1);
        chk("abort_frame_cnt", 64'(frame_cnt), 64'd1);
        chk("abort_beats", 64'(run_hs), 64'(FL + 5));
        exp_q.delete();
        run(2, 1000, 0, 0, 0);

        // Abort while idle is ignored
        @(posedge clk);
        #2 cmd_abort = 1'b1;
        @(posedge clk);
        #2 cmd_abort = 1'b0;
        @(negedge clk);
        chk("idle_abort", 64'({busy, aborted}), 64'd0);

        // Source end of buffer on and off frame boundaries
        run(2, 8, 0, 0, 0);
        run(2, 4, 0, 0, 0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("err_sticky", 64'(err_src_last), 64'd1);
        run(1, 1000, 0, 0, 0);

        // Reset in mid-stream discards the partial frame
        vmode = 0; rmode = 0; buf_len = 1000;
        @(posedge clk);
        push_exp(3 * FL);
        run_hs = 0;
        go(3);
        n = 0;
        while (run_hs < FL + 3 && n < 3000) begin
            @(posedge clk);
            n++;
        end
        d0 = done_cnt;
        #3 reset = 1'b1;
        #1;
        chk("midrst_outputs", 64'({busy, done, aborted, err_src_last, src_start, m_tvalid, s_tready, m_tlast}), 64'd0);
        chk("midrst_frame_cnt", 64'(frame_cnt), 64'd0);
        exp_q.delete();
        @(posedge clk);
        #2 reset = 1'b0;
        repeat (3) @(posedge clk);
        chk("midrst_no_done", 64'(done_cnt), 64'(d0));
        run(2, 1000, 0, 0, 1);

        // Randomized runs with source and consumer stalls
        for (int r = 0; r < 10; r++) begin
            run($urandom_range(1, 4), bls[$urandom_range(0, 6)],
                $urandom_range(0, 1), $urandom_range(0, 2), 1'b0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
